// File: rtl/pixel_filling_pkg.sv
// Shared types and helpers for the in-place pixel gap filler.
// State encoding, scan-direction constants and a width helper.
package pixel_filling_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR_C,
    ADDR_A,
    ADDR_B,
    EVAL,
    WRITE,
    DONE
  } state_t;

  localparam logic DIR_X = 1'b0;
  localparam logic DIR_Y = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = 1;
    while (x < v) begin
      x = x << 1;
      r = r + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/pixel_filling_addr_gen.sv
// Centre/neighbour address generator for the gap filler scan.
// Tracks the centre index, its column and the direction latched at start.
module pixel_filling_addr_gen
  import pixel_filling_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = 320,
  parameter int unsigned IMG_HEIGHT   = 240,
  parameter int unsigned MARGIN_LINES = 7,
  parameter int unsigned ADDR_W       = 18
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              dir_sel,
  output logic [ADDR_W-1:0] c,
  output logic [ADDR_W-1:0] c_nxt,
  output logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] b,
  output logic              skip,
  output logic              skip_nxt,
  output logic              last
);

  localparam int unsigned COL_W = clog2(IMG_WIDTH);
  localparam logic [ADDR_W-1:0] S =
    ADDR_W'(MARGIN_LINES * IMG_WIDTH);
  localparam logic [ADDR_W-1:0] E =
    ADDR_W'((IMG_HEIGHT - MARGIN_LINES) * IMG_WIDTH - 1);
  localparam logic [ADDR_W-1:0] W = ADDR_W'(IMG_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);

  logic [COL_W-1:0] col;
  logic [COL_W-1:0] col_nxt;
  logic             dir;
  logic             dir_nxt;

  function automatic logic is_edge(
    input logic             d,
    input logic [COL_W-1:0] k
  );
    return (d == DIR_X) && ((k == '0) || (k == COL_LAST));
  endfunction

  // S is a whole number of lines, so a pass always starts in column 0
  always_comb begin
    c_nxt   = c;
    col_nxt = col;
    dir_nxt = dir;
    if (start) begin
      c_nxt   = S;
      col_nxt = '0;
      dir_nxt = dir_sel;
    end else if (step) begin
      c_nxt   = c + ADDR_W'(1);
      col_nxt = (col == COL_LAST) ? '0 : col + COL_W'(1);
    end
  end

  assign a        = (dir == DIR_Y) ? c - W : c - ADDR_W'(1);
  assign b        = (dir == DIR_Y) ? c + W : c + ADDR_W'(1);
  assign skip     = is_edge(dir, col);
  assign skip_nxt = is_edge(dir_nxt, col_nxt);
  assign last     = (c == E);

  always_ff @(posedge clk) begin
    if (reset) begin
      c   <= '0;
      col <= '0;
      dir <= DIR_X;
    end else begin
      c   <= c_nxt;
      col <= col_nxt;
      dir <= dir_nxt;
    end
  end

endmodule

// File: rtl/pixel_gap_filler.sv
// In-place X/Y gap filler over the frame RAM active region.
// PIXEL_FILLING_TRISTATE_EN: release the RAM bus to Z while not enabled.
module pixel_gap_filler
  import pixel_filling_pkg::*;
#(
  parameter int unsigned       IMG_WIDTH    = 320,
  parameter int unsigned       IMG_HEIGHT   = 240,
  parameter int unsigned       MARGIN_LINES = 7,
  parameter int unsigned       ADDR_W       = 18,
  parameter int unsigned       DATA_W       = 32,
  parameter logic [DATA_W-1:0] FILL_VALUE   = DATA_W'(1)
) (
  input  logic              clk_div_by_two,
  input  logic              reset,
  input  logic              enable_pixel_filling,
  input  logic              direction,
  input  logic [DATA_W-1:0] data_read,
  output logic              wren,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_write,
  output logic              pixel_filling_done,
  output logic [ADDR_W-1:0] fill_count
);

  state_t state;
  state_t state_d;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic              wren_q;
  logic              wren_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;
  logic              done_d;
  logic [DATA_W-1:0] cen_q;
  logic [DATA_W-1:0] a_q;

  logic start;
  logic step;
  logic count_inc;
  logic cen_ld;
  logic a_ld;
  logic fill;

  logic [ADDR_W-1:0] c;
  logic [ADDR_W-1:0] c_nxt;
  logic [ADDR_W-1:0] a;
  logic [ADDR_W-1:0] b;
  logic              skip;
  logic              skip_nxt;
  logic              last;

  pixel_filling_addr_gen #(
    .IMG_WIDTH   (IMG_WIDTH),
    .IMG_HEIGHT  (IMG_HEIGHT),
    .MARGIN_LINES(MARGIN_LINES),
    .ADDR_W      (ADDR_W)
  ) u_addr_gen (
    .clk     (clk_div_by_two),
    .reset   (reset),
    .start   (start),
    .step    (step),
    .dir_sel (direction),
    .c       (c),
    .c_nxt   (c_nxt),
    .a       (a),
    .b       (b),
    .skip    (skip),
    .skip_nxt(skip_nxt),
    .last    (last)
  );

  // B arrives on data_read during EVAL; centre and A were latched earlier
  assign fill = (cen_q != FILL_VALUE) &&
                (a_q == FILL_VALUE) &&
                (data_read == FILL_VALUE);

  always_comb begin
    state_d   = state;
    start     = 1'b0;
    step      = 1'b0;
    count_inc = 1'b0;
    cen_ld    = 1'b0;
    a_ld      = 1'b0;
    if (!enable_pixel_filling) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          start   = 1'b1;
          state_d = ADDR_C;
        end
        ADDR_C: begin
          if (skip) begin
            step    = !last;
            state_d = last ? DONE : ADDR_C;
          end else begin
            state_d = ADDR_A;
          end
        end
        ADDR_A: begin
          cen_ld  = 1'b1;
          state_d = ADDR_B;
        end
        ADDR_B: begin
          a_ld    = 1'b1;
          state_d = EVAL;
        end
        EVAL: begin
          if (fill) begin
            count_inc = 1'b1;
            state_d   = WRITE;
          end else begin
            step    = !last;
            state_d = last ? DONE : ADDR_C;
          end
        end
        WRITE: begin
          step    = !last;
          state_d = last ? DONE : ADDR_C;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Bus outputs are registered from the state being entered
  always_comb begin
    addr_d  = '0;
    wren_d  = 1'b0;
    wdata_d = '0;
    done_d  = 1'b0;
    unique case (state_d)
      ADDR_C: addr_d = skip_nxt ? '0 : c_nxt;
      ADDR_A: addr_d = a;
      ADDR_B: addr_d = b;
      WRITE: begin
        addr_d  = c;
        wren_d  = 1'b1;
        wdata_d = FILL_VALUE;
      end
      DONE:    done_d = 1'b1;
      default: addr_d = '0;
    endcase
  end

  always_ff @(posedge clk_div_by_two) begin
    if (reset) begin
      state              <= IDLE;
      addr_q             <= '0;
      wren_q             <= 1'b0;
      wdata_q            <= '0;
      pixel_filling_done <= 1'b0;
      fill_count         <= '0;
      cen_q              <= '0;
      a_q                <= '0;
    end else begin
      state              <= state_d;
      addr_q             <= addr_d;
      wren_q             <= wren_d;
      wdata_q            <= wdata_d;
      pixel_filling_done <= done_d;
      if (start)
        fill_count <= '0;
      else if (count_inc)
        fill_count <= fill_count + ADDR_W'(1);
      if (cen_ld)
        cen_q <= data_read;
      if (a_ld)
        a_q <= data_read;
    end
  end

`ifdef PIXEL_FILLING_TRISTATE_EN
  assign address    = enable_pixel_filling ? addr_q  : 'z;
  assign data_write = enable_pixel_filling ? wdata_q : 'z;
  assign wren       = enable_pixel_filling ? wren_q  : 1'bz;
`else
  assign address    = addr_q;
  assign data_write = wdata_q;
  assign wren       = wren_q;
`endif

endmodule

// File: tb/tb_pixel_gap_filler.sv
// Randomised and directed bench for pixel_gap_filler on an 8x6 frame.
// A frame-level reference model predicts writes, counts and pass length.
module tb_pixel_gap_filler;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int M  = 1;
  localparam int AW = 18;
  localparam int DW = 32;
  localparam int S  = M * W;
  localparam int E  = (H - M) * W - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          direction;
  logic [DW-1:0] data_read;
  logic          wren;
  logic [AW-1:0] address;
  logic [DW-1:0] data_write;
  logic          done;
  logic [AW-1:0] fill_count;

  always #5 clk = ~clk;

  pixel_gap_filler #(
    .IMG_WIDTH   (W),
    .IMG_HEIGHT  (H),
    .MARGIN_LINES(M),
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .FILL_VALUE  (32'd1)
  ) dut (
    .clk_div_by_two      (clk),
    .reset               (reset),
    .enable_pixel_filling(enable),
    .direction           (direction),
    .data_read           (data_read),
    .wren                (wren),
    .address             (address),
    .data_write          (data_write),
    .pixel_filling_done  (done),
    .fill_count          (fill_count)
  );

  logic [DW-1:0] ram [64];
  int            wq[$];

  // Synchronous RAM: read data valid the cycle after the address
  always @(posedge clk) begin
    if (^address === 1'bx)
      data_read <= '0;
    else
      data_read <= ram[address[5:0]];
    if (wren === 1'b1) begin
      ram[address[5:0]] = data_write;
      wq.push_back(int'(address));
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] mm [64];
  int            exp_cnt;
  int            exp_cyc;
  int            exp_wq[$];

  // Raster walk applying the fill rule in place to a copy of the frame
  task automatic model(input logic d);
    exp_cnt = 0;
    exp_cyc = 1;
    exp_wq.delete();
    for (int i = 0; i < 64; i++) mm[i] = ram[i];
    for (int c = S; c <= E; c++) begin
      int col;
      int a;
      int b;
      col = c % W;
      if (!d && (col == 0 || col == W - 1)) begin
        exp_cyc += 1;
        continue;
      end
      a = d ? c - W : c - 1;
      b = d ? c + W : c + 1;
      if (mm[c] != 1 && mm[a] == 1 && mm[b] == 1) begin
        mm[c] = 1;
        exp_cnt++;
        exp_cyc += 5;
        exp_wq.push_back(c);
      end else begin
        exp_cyc += 4;
      end
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 64; i++) ram[i] = '0;
  endtask

  task automatic run_pass(input string tag, input logic d);
    int cyc;
    int bad;
    int wbad;
    model(d);
    wq.delete();
    @(negedge clk);
    direction = d;
    enable    = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    if (d) check({tag, "_first_addr"}, address, S);
    check({tag, "_cnt_clr"}, fill_count, 0);
    while (!done && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_cycles"}, cyc, exp_cyc);
    check({tag, "_count"}, fill_count, exp_cnt);
    check({tag, "_nwrites"}, wq.size(), exp_wq.size());
    wbad = 0;
    if (wq.size() == exp_wq.size())
      foreach (wq[i]) if (wq[i] != exp_wq[i]) wbad++;
    check({tag, "_wr_addrs"}, wbad, 0);
    bad = 0;
    for (int i = 0; i < 64; i++) if (ram[i] !== mm[i]) bad++;
    check({tag, "_frame"}, bad, 0);
    repeat (2) @(posedge clk);
    #1;
    check({tag, "_done_held"}, done, 1);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_clr"}, done, 0);
  endtask

  logic [AW-1:0] idle_addr;
  logic [DW-1:0] idle_wd;
  logic          idle_we;

  initial begin
    int cyc;
    int seen;
    logic [DW-1:0] v;
`ifdef PIXEL_FILLING_TRISTATE_EN
    idle_addr = 'z;
    idle_wd   = 'z;
    idle_we   = 1'bz;
`else
    idle_addr = '0;
    idle_wd   = '0;
    idle_we   = 1'b0;
`endif
    reset     = 1'b1;
    enable    = 1'b0;
    direction = 1'b0;
    clear_ram();
    repeat (3) @(posedge clk);
    #1;
    check("rst_wren", wren, idle_we);
    check("rst_addr", address, idle_addr);
    check("rst_wdata", data_write, idle_wd);
    check("rst_done", done, 0);
    check("rst_count", fill_count, 0);
    @(negedge clk);
    reset = 1'b0;

    clear_ram();
    ram[1]  = 1;
    ram[17] = 1;
    run_pass("y_single", 1'b1);
    check("y_single_w9", ram[9], 1);

    clear_ram();
    ram[10] = 1;
    ram[12] = 1;
    run_pass("x_single", 1'b0);
    check("x_single_w11", ram[11], 1);

    clear_ram();
    ram[2]  = 1;
    ram[26] = 1;
    run_pass("y_casc1", 1'b1);
    check("y_casc1_w10", ram[10], 0);
    check("y_casc1_w18", ram[18], 0);
    ram[18] = 1;
    run_pass("y_casc2", 1'b1);
    check("y_casc2_w10", ram[10], 1);

    // Abort during the first WRITE of a pass
    clear_ram();
    ram[1]  = 1;
    ram[17] = 1;
    ram[3]  = 1;
    ram[19] = 1;
    @(negedge clk);
    direction = 1'b1;
    enable    = 1'b1;
    cyc = 0;
    while (wren !== 1'b1 && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ab_wren_seen", wren, 1);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk); #1;
    check("ab_wren_off", wren, idle_we);
    check("ab_count_kept", fill_count, 1);
    seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    check("ab_no_done", seen, 0);
    run_pass("ab_restart", 1'b1);

    // Reset in the middle of an X pass with enable held high
    clear_ram();
    ram[9]  = 1;
    ram[11] = 1;
    @(negedge clk);
    direction = 1'b0;
    enable    = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("mr_pre_count", fill_count, 1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("mr_wren", wren, 0);
    check("mr_addr", address, 0);
    check("mr_wdata", data_write, 0);
    check("mr_done", done, 0);
    check("mr_count", fill_count, 0);
    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    @(posedge clk); #1;
    check("mr_idle_addr", address, idle_addr);
    check("mr_idle_wren", wren, idle_we);

    for (int p = 0; p < 16; p++) begin
      for (int i = 0; i < 64; i++) begin
        int r;
        r = int'($urandom_range(0, 9));
        v = (r < 5) ? 32'd1 : (r < 8) ? 32'd0 : 32'd7;
        ram[i] = v;
      end
      run_pass($sformatf("rnd%0d", p), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
